// File: rtl/mul_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, digit select codes, default width.
// Pure declarations; no logic, no latency, no flow control.
// The digit window is {q[2i+1], q[2i], q[2i-1]}, with an implied zero below bit 0.
package mul_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_ZERO = 3'd0,
        SEL_PM   = 3'd1,
        SEL_P2M  = 3'd2,
        SEL_NM   = 3'd3,
        SEL_N2M  = 3'd4
    } sel_e;

    function automatic sel_e booth_sel(input logic [2:0] win);
        sel_e s;
        case (win)
            3'b001, 3'b010: s = SEL_PM;
            3'b011:         s = SEL_P2M;
            3'b100:         s = SEL_N2M;
            3'b101, 3'b110: s = SEL_NM;
            default:        s = SEL_ZERO;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth digit encoder: 3-bit window -> {neg, two, zero} flags and signed addend.
// Purely combinational, zero latency; no handshake.
// The addend is WIDTH+2 bits so that -2M of the most negative M stays exact.
module booth_r4_enc
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       win_i,
    input  logic [WIDTH-1:0] m_i,
    output logic             neg_o,
    output logic             two_o,
    output logic             zero_o,
    output logic [WIDTH+1:0] addend_o
);

    sel_e             sel;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] mag;

    always_comb begin
        sel      = booth_sel(win_i);
        neg_o    = (sel == SEL_NM)  || (sel == SEL_N2M);
        two_o    = (sel == SEL_P2M) || (sel == SEL_N2M);
        zero_o   = (sel == SEL_ZERO);
        m_ext    = {{2{m_i[WIDTH-1]}}, m_i};
        mag      = two_o ? {m_ext[WIDTH:0], 1'b0} : m_ext;
        addend_o = zero_o ? '0 : (neg_o ? -mag : mag);
    end

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, one digit per cycle.
// Latency: done pulses WIDTH/2 edges after the accept edge (17th cycle counting the start cycle).
// Backpressure: start is ignored while busy; accepted in IDLE or DONE, so ops can run back to back.
module booth_mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   M,
    input  logic [WIDTH-1:0]   Q,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] z
);

    localparam int            DIGITS   = WIDTH / 2;
    localparam int            CW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               qm1_q, qm1_d;
    logic [WIDTH+1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] z_q, z_d;

    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   sum;
    logic [WIDTH+1:0]   acc_sh;
    logic [WIDTH-1:0]   mq_sh;
    logic [2:0]         sel_unused;

    booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
        .win_i    ({mq_q[1:0], qm1_q}),
        .m_i      (m_q),
        .neg_o    (sel_unused[2]),
        .two_o    (sel_unused[1]),
        .zero_o   (sel_unused[0]),
        .addend_o (addend)
    );

    // Add the digit into the upper half, then shift {acc, mq, qm1} right by two arithmetically.
    always_comb begin
        sum    = acc_q + addend;
        acc_sh = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        mq_sh  = {sum[1:0], mq_q[WIDTH-1:2]};
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done    = (state_q == DONE);
                state_d = IDLE;
                if (start) begin
                    m_d     = M;
                    mq_d    = Q;
                    qm1_d   = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                acc_d = acc_sh;
                mq_d  = mq_sh;
                qm1_d = mq_q[1];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    z_d     = {acc_sh[WIDTH-1:0], mq_sh};
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        z = z_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m_q     <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed vector table, handshake corner cases,
// mid-operation reset and randomized operands against a plain-arithmetic product model.
module tb_booth_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] M;
    logic [31:0] Q;
    logic        busy;
    logic        done;
    logic [63:0] z;

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [63:0] z;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    booth_mul_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .M     (M),
        .Q     (Q),
        .busy  (busy),
        .done  (done),
        .z     (z)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'h7FFF_FFFF;
            3:       v = 32'hFFFF_FFFF;
            4:       v = 32'h0000_0001;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            nchk++;
            if (busy && done) begin
                nerr++;
                $display("FAIL busy_done_overlap: busy=%b done=%b, expected not both high", busy, done);
            end
        end
    end

    // Present operands with start for one edge, then scramble M/Q to prove they were latched.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        M     = a;
        Q     = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        M     = $urandom;
        Q     = $urandom;
    endtask

    // Called at the negedge right after the accept edge; lat counts edges including the accept edge.
    task automatic wait_done(output int lat, output int bcnt);
        int cyc;
        cyc  = 0;
        bcnt = 0;
        lat  = -1;
        while (cyc < 40) begin
            if (done) begin
                lat = cyc + 1;
                break;
            end
            if (busy) bcnt++;
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string nm);
        int lat;
        int bc;
        issue(a, b);
        wait_done(lat, bc);
        chk({nm, " z"}, z, exp);
        chk({nm, " latency"}, 64'(lat), 64'd17);
        chk({nm, " busy_cycles"}, 64'(bc), 64'd16);
        @(negedge clk);
        chk({nm, " done_width"}, {63'd0, done}, 64'd0);
        chk({nm, " z_hold"}, z, exp);
    endtask

    initial begin
        int          lat;
        int          bc;
        int          nd;
        logic [63:0] zd;
        logic [31:0] a;
        logic [31:0] b;

        rst_n = 1'b1;
        start = 1'b0;
        M     = '0;
        Q     = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset z", z, 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{32'h0000_0002, 32'h0000_0001, 64'h0000_0000_0000_0002};
        tbl[1] = '{32'h0000_0004, 32'h0000_0002, 64'h0000_0000_0000_0008};
        tbl[2] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        tbl[3] = '{32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        tbl[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
        tbl[5] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        tbl[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
        tbl[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
        tbl[8] = '{32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].m, tbl[i].q, tbl[i].z, $sformatf("vec%0d", i));
        end

        // start during RUN cycle 5 must be dropped entirely
        issue(32'hFFFF_FF00, 32'h0000_1234);
        repeat (4) @(negedge clk);
        M     = 32'h0000_1111;
        Q     = 32'h0000_0003;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        zd = '0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                nd++;
                zd = z;
            end
            @(negedge clk);
        end
        chk("busy_start done_count", 64'(nd), 64'd1);
        chk("busy_start z", zd, ref_mul(32'hFFFF_FF00, 32'h0000_1234));

        // start asserted while in DONE: accepted with no lost cycle
        issue(32'h0000_0123, 32'hFFFF_FFF0);
        wait_done(lat, bc);
        chk("b2b first z", z, ref_mul(32'h0000_0123, 32'hFFFF_FFF0));
        M     = 32'hDEAD_BEEF;
        Q     = 32'h0000_0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b accepted busy", {63'd0, busy}, 64'd1);
        wait_done(lat, bc);
        chk("b2b second latency", 64'(lat), 64'd17);
        chk("b2b second z", z, ref_mul(32'hDEAD_BEEF, 32'h0000_0010));
        @(negedge clk);

        // asynchronous reset in the middle of an operation
        do_op(32'h0000_0005, 32'h0000_0006, 64'd30, "pre_reset");
        issue(32'h0000_0007, 32'h0000_0009);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", {63'd0, busy}, 64'd0);
        chk("midrst done", {63'd0, done}, 64'd0);
        chk("midrst z", z, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("midrst no_done", 64'(nd), 64'd0);
        do_op(32'hFFFF_FFFB, 32'h0000_000B, ref_mul(32'hFFFF_FFFB, 32'h0000_000B), "post_reset");

        for (int i = 0; i < 1000; i++) begin
            a = pick();
            b = pick();
            do_op(a, b, ref_mul(a, b), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
